// File: rtl/apb_timeout_shim_if.sv
// rtl/apb_timeout_shim_if.sv - APB3 bus bundle with master/slave views for the timeout shim
interface apb_timeout_shim_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timeout_shim.sv
// rtl/apb_timeout_shim.sv - APB3 stall guard re-issuing transfers with PREADY timeout abort (option: APB_TIMEOUT_STATS_EN)
module apb_timeout_shim #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  apb_timeout_shim_if.slave        s_apb,
  apb_timeout_shim_if.master       m_apb,
  output logic                     timeout_o,
  output logic                     busy_o
`ifdef APB_TIMEOUT_STATS_EN
  ,
  output logic [15:0]              timeout_cnt_o
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             abort;

  // Last tolerated not-ready ACCESS cycle; a ready on this same cycle still completes normally
  assign abort = (state == ACCESS) && !m_apb.pready && (wait_cnt >= CNT_LAST);

  // Transfer sequencer: every bus-facing output is a register updated here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      m_apb.psel     <= 1'b0;
      m_apb.penable  <= 1'b0;
      m_apb.pwrite   <= 1'b0;
      m_apb.paddr    <= '0;
      m_apb.pwdata   <= '0;
      s_apb.prdata   <= '0;
      s_apb.pready   <= 1'b0;
      s_apb.pslverr  <= 1'b0;
      timeout_o      <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (s_apb.psel && !s_apb.penable) begin
            m_apb.pwrite  <= s_apb.pwrite;
            m_apb.paddr   <= s_apb.paddr;
            m_apb.pwdata  <= s_apb.pwdata;
            m_apb.psel    <= 1'b1;
            m_apb.penable <= 1'b0;
            busy_o        <= 1'b1;
            state         <= SETUP;
          end
        end
        SETUP: begin
          m_apb.penable <= 1'b1;
          wait_cnt      <= '0;
          state         <= ACCESS;
        end
        ACCESS: begin
          if (m_apb.pready) begin
            s_apb.prdata  <= m_apb.pwrite ? '0 : m_apb.prdata;
            s_apb.pslverr <= m_apb.pslverr;
            s_apb.pready  <= 1'b1;
            m_apb.psel    <= 1'b0;
            m_apb.penable <= 1'b0;
            state         <= RESP;
          end else begin
            // Saturate rather than wrap so a stuck count can never look "fresh"
            if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
            if (abort) begin
              // Release the hung slave and answer upstream with an error
              s_apb.prdata  <= '0;
              s_apb.pslverr <= 1'b1;
              s_apb.pready  <= 1'b1;
              m_apb.psel    <= 1'b0;
              m_apb.penable <= 1'b0;
              timeout_o     <= 1'b1;
              state         <= RESP;
            end
          end
        end
        RESP: begin
          s_apb.pready <= 1'b0;
          busy_o       <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef APB_TIMEOUT_STATS_EN
  logic [15:0] stat_cnt;

  // Abort statistics: steps together with the timeout_o pulse, sticks at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_cnt <= '0;
    end else if (abort && (stat_cnt != 16'hFFFF)) begin
      stat_cnt <= stat_cnt + 16'd1;
    end
  end

  assign timeout_cnt_o = stat_cnt;
`endif

endmodule
